beam_power_trigger: RTL and testbench
=====================================

# beam_power_trigger

Sliding-window power discriminator directly downstream of the 8-way 5-bit ternary adder tree. Each cycle it takes the adder's 8-bit beam sum and keeps a running sum over the last 2^WINDOW_LOG2 samples. It compares that sum against a programmable threshold and issues single-cycle trigger pulses with a programmable holdoff. It also keeps a saturating trigger count for the register interface.

## Interface
Parameters:
- WINDOW_LOG2, 3: log2 of window length (window N = 8 samples by default); legal 1..5.
- HOLD_W, 8: width of the holdoff counter/port.
- CNT_W, 16: width of the trigger counter.

Ports:
- clk_i  in  1  single clock, shared with the adder tree.
- rst_i  in  1  synchronous reset, active-high.
- sum_i  in  8  beam sum from the adder tree output O.
- sum_valid_i  in  1  sum_i valid this cycle; window advances only when high.
- thresh_i  in  8+WINDOW_LOG2  new threshold value.
- thresh_wr_i  in  1  load thresh_i into threshold register.
- holdoff_i  in  HOLD_W  holdoff length in cycles, sampled at trigger time.
- power_o  out  8+WINDOW_LOG2  current registered window sum.
- trig_o  out  1  one-cycle trigger pulse.
- armed_o  out  1  high in ARMED state.
- trig_count_o  out  CNT_W  triggers since reset, saturating.

## Operation
- Delay line: N-deep shift register of 8-bit samples. It advances only on sum_valid_i.
- Running sum update on valid: acc <= acc + sum_i - oldest.
- Width SUM_W = 8+WINDOW_LOG2. This width is exact: it cannot overflow, because max is N*255.
- Fill counter counts valid samples 0..N, then holds at N.
- Threshold register:
  - Reset value is all-ones (never fires).
  - thresh_wr_i loads it at the next edge.
  - The new value is used for comparisons starting the cycle after the load.
- Compare is strict: acc > threshold.
- FSM states:
  - FILL: after reset. Goes to ARMED when the fill count reaches N. No triggers while in FILL.
  - ARMED: when the compare is true on a cycle with a valid update, assert trig_o, load the holdoff counter with holdoff_i, and go to HOLDOFF. If holdoff_i == 0, stay in ARMED; the next qualifying valid can trigger on the following cycle.
  - HOLDOFF: decrement every clock, independent of valid. Go to ARMED on the cycle the count reaches 1→0. Compares are ignored.
- Accumulator and delay line keep running in every state.
- trig_count_o increments on each trig_o and saturates at 2^CNT_W-1.
- Reset mid-operation clears the following and returns the FSM to FILL:
  - delay line, acc, fill count, holdoff, trig_count_o → 0
  - threshold → all-ones
- Simultaneous thresh_wr_i and trigger condition: the compare uses the old threshold.

## Timing
- Reset values: power_o=0, trig_o=0, armed_o=0, trig_count_o=0.
- Sample path: sum_i valid at edge k → acc/power_o updated at edge k+1. The compare uses the registered acc, so trig_o is asserted registered at edge k+2. Latency sum_i→trig_o is 2 cycles.
- trig_o is exactly one cycle wide.
- armed_o is registered and goes low in the same cycle trig_o is high.
- Minimum trigger spacing: holdoff_i+1 cycles.
- trig_count_o updates in the cycle after trig_o.
- No combinational input→output paths.

## Structure
- Shared package beam_trig_pkg holds:
  - SUM_W derivation function
  - FSM enum (ST_FILL, ST_ARMED, ST_HOLDOFF)
  - default threshold constant (all-ones)
- One natural sub-module, window_accum: delay line, running sum and fill count, with N as a parameter. The top holds the FSM, threshold register, holdoff and counter.

## Test plan
- Fill: rst_i for 4 cycles, then sum_i=10 continuously valid, thresh=0.
  - No trig_o during the first 8 samples.
  - power_o reaches 80 after the 8th sample.
  - First trig_o comes 2 cycles after the 8th sample.
- Threshold crossing: thresh=200, holdoff=0.
  - Constant 25 → power 200, no trigger (strict compare).
  - Step to 26 → trig_o 2 cycles after the power_o that exceeds 200.
  - With the window held above threshold, triggers repeat every cycle.
- Holdoff: thresh=0, holdoff_i=5, constant 255 → trig_o every 6 cycles; trig_count_o increments by 1 per pulse.
- Valid gaps: sum_valid_i toggled 1,0,1,0 with values 0..15 → power_o equals the sum of the last 8 valid samples only; it is unchanged on invalid cycles.
- Reset mid-holdoff: assert rst_i 2 cycles after a trigger → all outputs 0 the next cycle, FSM back in FILL, threshold all-ones.
- Threshold write collision: thresh_wr_i with a high value on the same cycle as the trigger condition → trigger still fires (old threshold). The next window exceeding only the old value gives no trigger. Also a saturation check: with CNT_W=4, 20 triggers → trig_count_o=15.

Source files
------------

// File: rtl/beam_trig_pkg.sv
// -----------------------------------------------------------------------------
// beam_trig_pkg
// Shared definitions for the beam power trigger slice:
//   - sample width of the adder-tree beam sum
//   - sum_w(): exact width of a window sum of 2^window_log2 samples
//   - trig_state_e: trigger FSM states
//   - THRESH_DEFAULT: all-ones threshold, wide enough for the largest window
// -----------------------------------------------------------------------------
package beam_trig_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int MAX_WINDOW_LOG2 = 5;
  localparam int MAX_SUM_W       = SAMPLE_W + MAX_WINDOW_LOG2;

  // Threshold reset value. A window sum can never exceed all-ones, so the
  // trigger stays silent until software programs a real threshold.
  localparam logic [MAX_SUM_W-1:0] THRESH_DEFAULT = '1;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ARMED,
    ST_HOLDOFF
  } trig_state_e;

  // N * 255 < 2^(8 + log2 N), so this width holds any window sum exactly.
  function automatic int sum_w(input int window_log2);
    return SAMPLE_W + window_log2;
  endfunction

endpackage

// File: rtl/window_accum.sv
// -----------------------------------------------------------------------------
// window_accum
// Sliding-window running sum over the last N valid samples.
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   sample_i     8-bit beam sum
//   valid_i      sample_i valid; the window advances only when high
//   acc_o        registered sum of the last N valid samples
//   upd_o        registered: acc_o was updated by the previous edge
//   full_next_o  the fill count is N, or reaches N at the coming edge
// -----------------------------------------------------------------------------
module window_accum
  import beam_trig_pkg::*;
#(
  parameter int N     = 8,
  parameter int SUM_W = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  output logic [SUM_W-1:0]    acc_o,
  output logic                upd_o,
  output logic                full_next_o
);

  localparam int FILL_W = $clog2(N + 1);

  logic [SAMPLE_W-1:0] line_q [N];
  logic [FILL_W-1:0]   fill_q;

  // NOTE: all state here uses non-blocking assignments so the shift register
  // stages and the accumulator all see the pre-edge values of each other.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the delay line is a memory that is deliberately reset: acc_o
      // subtracts the oldest entry, so stale contents would corrupt the sum.
      for (int i = 0; i < N; i++) begin
        line_q[i] <= '0;
      end
      acc_o  <= '0;
      upd_o  <= 1'b0;
      fill_q <= '0;
    end else begin
      upd_o <= valid_i;
      if (valid_i) begin
        line_q[0] <= sample_i;
        for (int i = 1; i < N; i++) begin
          line_q[i] <= line_q[i-1];
        end
        // Oldest entry is zero until the line has filled, so the same update
        // works during fill and in steady state.
        acc_o <= acc_o + SUM_W'(sample_i) - SUM_W'(line_q[N-1]);
        if (fill_q != FILL_W'(N)) begin
          fill_q <= fill_q + 1'b1;
        end
      end
    end
  end

  // Lets the FSM leave FILL on the same edge that lands the Nth sample, so
  // the first compare happens on the very first full window.
  assign full_next_o = (fill_q == FILL_W'(N)) ||
                       (valid_i && (fill_q == FILL_W'(N - 1)));

endmodule

// File: rtl/beam_power_trigger.sv
// -----------------------------------------------------------------------------
// beam_power_trigger
// Sliding-window power discriminator behind the beam adder tree. Keeps a
// running sum over the last 2^WINDOW_LOG2 valid samples, compares it strictly
// against a programmable threshold and issues one-cycle trigger pulses with a
// programmable holdoff. A saturating trigger count is kept for software.
//   clk_i         clock, shared with the adder tree
//   rst_i         synchronous active-high reset
//   sum_i         8-bit beam sum
//   sum_valid_i   sum_i valid this cycle
//   thresh_i      threshold value, loaded on thresh_wr_i
//   thresh_wr_i   threshold load strobe
//   holdoff_i     holdoff length in cycles, sampled when a trigger fires
//   power_o       registered window sum
//   trig_o        one-cycle trigger pulse
//   armed_o       high while the FSM is in ARMED
//   trig_count_o  triggers since reset, saturating
// -----------------------------------------------------------------------------
module beam_power_trigger
  import beam_trig_pkg::*;
#(
  parameter  int WINDOW_LOG2 = 3,
  parameter  int HOLD_W      = 8,
  parameter  int CNT_W       = 16,
  localparam int SUM_W       = sum_w(WINDOW_LOG2)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] sum_i,
  input  logic                sum_valid_i,
  input  logic [SUM_W-1:0]    thresh_i,
  input  logic                thresh_wr_i,
  input  logic [HOLD_W-1:0]   holdoff_i,
  output logic [SUM_W-1:0]    power_o,
  output logic                trig_o,
  output logic                armed_o,
  output logic [CNT_W-1:0]    trig_count_o
);

  localparam int N = 1 << WINDOW_LOG2;

  trig_state_e       state_q;
  logic [SUM_W-1:0]  thresh_q;
  logic [HOLD_W-1:0] hold_q;
  logic              upd;
  logic              full_next;
  logic              hit;

  window_accum #(
    .N     (N),
    .SUM_W (SUM_W)
  ) u_accum (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sample_i    (sum_i),
    .valid_i     (sum_valid_i),
    .acc_o       (power_o),
    .upd_o       (upd),
    .full_next_o (full_next)
  );

  // Only a freshly updated window may trigger; the compare is on the
  // registered sum, which puts trig_o two edges after the sample.
  assign hit = upd && (power_o > thresh_q);

  // A write lands at the edge, so a compare on the same edge still sees the
  // old threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      thresh_q <= THRESH_DEFAULT[SUM_W-1:0];
    end else if (thresh_wr_i) begin
      thresh_q <= thresh_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FILL;
      hold_q  <= '0;
      trig_o  <= 1'b0;
      armed_o <= 1'b0;
    end else begin
      trig_o <= 1'b0;
      unique case (state_q)
        ST_FILL: begin
          if (full_next) begin
            state_q <= ST_ARMED;
            armed_o <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (hit) begin
            trig_o <= 1'b1;
            hold_q <= holdoff_i;
            // Zero holdoff: stay armed so the next valid window can fire on
            // the following cycle.
            if (holdoff_i != '0) begin
              state_q <= ST_HOLDOFF;
              armed_o <= 1'b0;
            end
          end
        end
        ST_HOLDOFF: begin
          // Counts clocks, not samples; rearms as the count goes 1 -> 0.
          hold_q <= hold_q - 1'b1;
          if (hold_q == HOLD_W'(1)) begin
            state_q <= ST_ARMED;
            armed_o <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_FILL;
          armed_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_count_o <= '0;
    end else if (trig_o && (trig_count_o != '1)) begin
      trig_count_o <= trig_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_beam_power_trigger.sv
// -----------------------------------------------------------------------------
// tb_beam_power_trigger
// Directed bench for beam_power_trigger (default parameters) with a second
// instance using CNT_W=4 that shares the same stimulus for counter saturation.
// Inputs are driven between edges; outputs are sampled 1 time unit after the
// rising edge, so each tick() shows the state produced by that edge.
// -----------------------------------------------------------------------------
module tb_beam_power_trigger;

  localparam int SUM_W  = 11;
  localparam int HOLD_W = 8;

  typedef struct {
    logic             valid;
    logic [7:0]       sum;
    logic             wr;
    logic [SUM_W-1:0] thr;
    int               exp_power;  // -1: not checked
    logic             exp_trig;
    int               exp_armed;  // -1: not checked
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [7:0]        sum_i;
  logic              sum_valid_i;
  logic [SUM_W-1:0]  thresh_i;
  logic              thresh_wr_i;
  logic [HOLD_W-1:0] holdoff_i;
  logic [SUM_W-1:0]  power_o, power4;
  logic              trig_o, trig4;
  logic              armed_o, armed4;
  logic [15:0]       trig_count_o;
  logic [3:0]        count4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  beam_power_trigger dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sum_i        (sum_i),
    .sum_valid_i  (sum_valid_i),
    .thresh_i     (thresh_i),
    .thresh_wr_i  (thresh_wr_i),
    .holdoff_i    (holdoff_i),
    .power_o      (power_o),
    .trig_o       (trig_o),
    .armed_o      (armed_o),
    .trig_count_o (trig_count_o)
  );

  beam_power_trigger #(.CNT_W(4)) dut4 (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sum_i        (sum_i),
    .sum_valid_i  (sum_valid_i),
    .thresh_i     (thresh_i),
    .thresh_wr_i  (thresh_wr_i),
    .holdoff_i    (holdoff_i),
    .power_o      (power4),
    .trig_o       (trig4),
    .armed_o      (armed4),
    .trig_count_o (count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_i       = 1'b1;
    sum_valid_i = 1'b0;
    sum_i       = '0;
    thresh_wr_i = 1'b0;
    repeat (cycles) tick();
    rst_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic valid, input logic [7:0] sum, input logic wr,
                              input int thr, input int exp_power, input logic exp_trig,
                              input int exp_armed);
    vec_t v;
    v.valid     = valid;
    v.sum       = sum;
    v.wr        = wr;
    v.thr       = SUM_W'(thr);
    v.exp_power = exp_power;
    v.exp_trig  = exp_trig;
    v.exp_armed = exp_armed;
    return v;
  endfunction

  task automatic run_vecs(input string tag, input vec_t vecs[$]);
    foreach (vecs[i]) begin
      sum_valid_i = vecs[i].valid;
      sum_i       = vecs[i].sum;
      thresh_wr_i = vecs[i].wr;
      thresh_i    = vecs[i].thr;
      tick();
      if (vecs[i].exp_power >= 0)
        check($sformatf("%s[%0d].power", tag, i), 32'(power_o), vecs[i].exp_power);
      check($sformatf("%s[%0d].trig", tag, i), 32'(trig_o), 32'(vecs[i].exp_trig));
      if (vecs[i].exp_armed >= 0)
        check($sformatf("%s[%0d].armed", tag, i), 32'(armed_o), vecs[i].exp_armed);
    end
    thresh_wr_i = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    int   win[$];
    int   exp_sum;
    int   exp_cnt;

    rst_i       = 1'b1;
    sum_i       = '0;
    sum_valid_i = 1'b0;
    thresh_i    = '0;
    thresh_wr_i = 1'b0;
    holdoff_i   = '0;

    // Reset state
    do_reset(4);
    check("reset.power", 32'(power_o), 0);
    check("reset.trig", 32'(trig_o), 0);
    check("reset.armed", 32'(armed_o), 0);
    check("reset.count", 32'(trig_count_o), 0);

    // Fill: 10 per sample, threshold 0; first trigger two edges after sample 8
    vecs.delete();
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 8'd10, i == 1, 0, 10 * i, 1'b0, (i == 8) ? 1 : 0));
    vecs.push_back(mk(1'b1, 8'd10, 1'b0, 0, 80, 1'b1, 1));
    vecs.push_back(mk(1'b1, 8'd10, 1'b0, 0, 80, 1'b1, 1));
    run_vecs("fill", vecs);

    // Threshold crossing: 200 is not above 200; 201 and up fire every cycle
    do_reset(1);
    vecs.delete();
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 8'd25, i == 1, 200, 25 * i, 1'b0, -1));
    vecs.push_back(mk(1'b1, 8'd25, 1'b0, 200, 200, 1'b0, 1));
    vecs.push_back(mk(1'b1, 8'd25, 1'b0, 200, 200, 1'b0, 1));
    vecs.push_back(mk(1'b1, 8'd26, 1'b0, 200, 201, 1'b0, 1));
    vecs.push_back(mk(1'b1, 8'd26, 1'b0, 200, 202, 1'b1, 1));
    vecs.push_back(mk(1'b1, 8'd26, 1'b0, 200, 203, 1'b1, 1));
    vecs.push_back(mk(1'b1, 8'd26, 1'b0, 200, 204, 1'b1, 1));
    run_vecs("cross", vecs);

    // Valid gaps: only even-indexed samples are valid; sum of last 8 valid
    do_reset(1);
    win.delete();
    for (int i = 0; i < 32; i++) begin
      sum_valid_i = (i % 2 == 0);
      sum_i       = 8'(i);
      if (i % 2 == 0) begin
        win.push_back(i);
        if (win.size() > 8) void'(win.pop_front());
      end
      tick();
      exp_sum = 0;
      foreach (win[j]) exp_sum += win[j];
      check($sformatf("gaps[%0d].power", i), 32'(power_o), exp_sum);
      check($sformatf("gaps[%0d].trig", i), 32'(trig_o), 0);
    end

    // Holdoff 5, constant 255: trigger every 6 cycles, armed low in between
    do_reset(1);
    holdoff_i = 8'd5;
    vecs.delete();
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 8'd255, i == 1, 0, 255 * i, 1'b0, (i == 8) ? 1 : 0));
    run_vecs("hold_fill", vecs);
    exp_cnt = 0;
    for (int t = 9; t <= 28; t++) begin
      logic exp_trig;
      exp_trig    = ((t - 9) % 6 == 0);
      sum_valid_i = 1'b1;
      sum_i       = 8'd255;
      tick();
      check($sformatf("hold[%0d].trig", t), 32'(trig_o), 32'(exp_trig));
      check($sformatf("hold[%0d].armed", t), 32'(armed_o), 32'((t - 9) % 6 == 5));
      check($sformatf("hold[%0d].count", t), 32'(trig_count_o), exp_cnt);
      if (exp_trig) exp_cnt++;
    end
    check("hold.power", 32'(power_o), 2040);

    // Reset two cycles after the trigger at t=27, while in holdoff
    rst_i = 1'b1;
    tick();
    check("midrst.power", 32'(power_o), 0);
    check("midrst.trig", 32'(trig_o), 0);
    check("midrst.armed", 32'(armed_o), 0);
    check("midrst.count", 32'(trig_count_o), 0);
    rst_i     = 1'b0;
    holdoff_i = '0;
    // Back in FILL with an all-ones threshold: 2040 must never fire
    vecs.delete();
    for (int i = 1; i <= 11; i++)
      vecs.push_back(mk(1'b1, 8'd255, 1'b0, 0, (i < 8) ? 255 * i : 2040, 1'b0,
                        (i >= 8) ? 1 : 0));
    run_vecs("postrst", vecs);

    // Threshold write on the trigger edge: old threshold 100 still applies,
    // then 104 is below the new 150
    do_reset(1);
    vecs.delete();
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b1, 8'd12, i == 1, 100, 12 * i, 1'b0, -1));
    vecs.push_back(mk(1'b1, 8'd20, 1'b0, 100, 104, 1'b0, 1));
    vecs.push_back(mk(1'b1, 8'd12, 1'b1, 150, 104, 1'b1, 1));
    vecs.push_back(mk(1'b1, 8'd12, 1'b0, 150, 104, 1'b0, 1));
    vecs.push_back(mk(1'b1, 8'd12, 1'b0, 150, 104, 1'b0, 1));
    run_vecs("collide", vecs);

    // Saturation: 20 triggers (edges 9..28) -> 20 on CNT_W=16, 15 on CNT_W=4
    do_reset(1);
    holdoff_i   = '0;
    thresh_i    = '0;
    thresh_wr_i = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      sum_valid_i = (t <= 27);
      sum_i       = 8'd255;
      tick();
      thresh_wr_i = 1'b0;
    end
    check("sat.count16", 32'(trig_count_o), 20);
    check("sat.count4", 32'(count4), 15);
    check("sat.trig4", 32'(trig4), 0);
    check("sat.power4", 32'(power4), 2040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
